// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, indexes a combinational instruction
// memory and buffers {pc, instr} pairs in a small FIFO toward decode.
module fetch_unit #(
  parameter int unsigned             ADDR_WIDTH  = 32,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
  parameter int unsigned             FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [ADDR_WIDTH-1:0]  pc_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [ADDR_WIDTH-1:0]  mem_pc_q    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] mem_instr_q [FIFO_DEPTH];

  logic push, pop;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_addr = {2'b00, pc_q[ADDR_WIDTH-1:2]};
  assign pc_o      = pc_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = fetch_en & ~redirect_valid & ((count_q < CntFull) | pop);

  assign out_instr = out_valid ? mem_instr_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? mem_pc_q[rd_ptr_q]    : '0;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDR_WIDTH'(4);
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_pc_q[wr_ptr_q]    <= pc_q;
        mem_instr_q[wr_ptr_q] <= imem_instr;
      end
    end
  end

endmodule
